alu_issue_stage: RTL and testbench

//  ID->EX issue register and control generator for the ALU.
//  - Decodes RV64I instruction fields into the 2-bit ALU control code and selects SrcA/SrcB operands.
//  - Holds the result in a one-entry valid/ready pipeline register that feeds the ALU in EX.
//  - Emits a branch-condition code so the EX branch logic can read ALUFlags {V,C,N,Z}.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_ctrl_decode.sv | 79 +++++++
 rtl/alu_issue_stage.sv | 103 ++++++++++
 tb/tb_alu_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode constants and branch-condition encoding
// for the ID->EX issue stage.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // Bit positions inside ALUFlags {V,C,N,Z}
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [2:0] {
    BrNone = 3'b000,
    BrEq   = 3'b001,
    BrNe   = 3'b010,
    BrLt   = 3'b011,
    BrGe   = 3'b100,
    BrLtu  = 3'b101,
    BrGeu  = 3'b110
  } br_cond_t;

  typedef enum logic [1:0] {
    ImmNone = 2'b00,
    ImmI    = 2'b01,
    ImmS    = 2'b10
  } imm_sel_t;

  function automatic logic [11:0] imm_s_field(input logic [31:0] instr);
    return {instr[31:25], instr[11:7]};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of an RV64I instruction word into ALU control code,
// branch condition, immediate select and an illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [1:0]  o_alu_ctrl,
  output logic [2:0]  o_br_cond,
  output logic [1:0]  o_imm_sel,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [1:0] w_alu;
  br_cond_t   w_br;
  imm_sel_t   w_imm;
  logic       w_ill;
  logic       w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  // Register indices are consumed by the register file, not here
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    w_alu = ALU_ADD;
    w_br  = BrNone;
    w_imm = ImmNone;
    w_ill = 1'b0;
    case (w_opcode)
      OP: begin
        if (w_f3 == 3'b000 && w_f7 == 7'b0000000)      w_alu = ALU_ADD;
        else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) w_alu = ALU_SUB;
        else if (w_f3 == 3'b111 && w_f7 == 7'b0000000) w_alu = ALU_AND;
        else if (w_f3 == 3'b110 && w_f7 == 7'b0000000) w_alu = ALU_OR;
        else                                           w_ill = 1'b1;
      end
      OP_IMM: begin
        w_imm = ImmI;
        case (w_f3)
          3'b000:  w_alu = ALU_ADD;
          3'b111:  w_alu = ALU_AND;
          3'b110:  w_alu = ALU_OR;
          default: w_ill = 1'b1;
        endcase
      end
      LOAD:  w_imm = ImmI;
      STORE: w_imm = ImmS;
      BRANCH: begin
        w_alu = ALU_SUB;
        case (w_f3)
          3'b000:  w_br = BrEq;
          3'b001:  w_br = BrNe;
          3'b100:  w_br = BrLt;
          3'b101:  w_br = BrGe;
          3'b110:  w_br = BrLtu;
          3'b111:  w_br = BrGeu;
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries still flow down the pipe but must carry neutral controls
    if (w_ill) begin
      w_alu = ALU_ADD;
      w_br  = BrNone;
      w_imm = ImmNone;
    end
  end

  assign o_alu_ctrl = w_alu;
  assign o_br_cond  = w_br;
  assign o_imm_sel  = w_imm;
  assign o_illegal  = w_ill;

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes ALU controls, muxes operands and holds them
// in a one-entry valid/ready pipeline register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [BITS-1:0] rs1_val,
  input  logic [BITS-1:0] rs2_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] SrcA,
  output logic [BITS-1:0] SrcB,
  output logic [1:0]      ALUControl,
  output logic [2:0]      br_cond,
  output logic [BITS-1:0] st_data,
  output logic            illegal
);

  logic [1:0]      w_alu_ctrl;
  logic [2:0]      w_br_cond;
  logic [1:0]      w_imm_sel;
  logic            w_illegal;
  logic [BITS-1:0] w_imm_i;
  logic [BITS-1:0] w_imm_s;
  logic [BITS-1:0] w_src_b;
  logic            w_accept;

  logic            r_valid;
  logic [BITS-1:0] r_src_a;
  logic [BITS-1:0] r_src_b;
  logic [1:0]      r_alu_ctrl;
  logic [2:0]      r_br_cond;
  logic [BITS-1:0] r_st_data;
  logic            r_illegal;

  alu_ctrl_decode u_decode (
    .i_instr    (instr),
    .o_alu_ctrl (w_alu_ctrl),
    .o_br_cond  (w_br_cond),
    .o_imm_sel  (w_imm_sel),
    .o_illegal  (w_illegal)
  );

  assign w_imm_i = {{(BITS-12){instr[31]}}, instr[31:20]};
  assign w_imm_s = {{(BITS-12){instr[31]}}, imm_s_field(instr)};

  always_comb begin
    w_src_b = rs2_val;
    case (w_imm_sel)
      ImmI:    w_src_b = w_imm_i;
      ImmS:    w_src_b = w_imm_s;
      default: w_src_b = rs2_val;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  // Flush wins over a load in the same cycle
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_src_a    <= '0;
      r_src_b    <= '0;
      r_alu_ctrl <= ALU_ADD;
      r_br_cond  <= BrNone;
      r_st_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_src_a    <= rs1_val;
        r_src_b    <= w_src_b;
        r_alu_ctrl <= w_alu_ctrl;
        r_br_cond  <= w_br_cond;
        r_st_data  <= rs2_val;
        r_illegal  <= w_illegal;
      end
    end
  end

  assign out_valid  = r_valid;
  assign SrcA       = r_src_a;
  assign SrcB       = r_src_b;
  assign ALUControl = r_alu_ctrl;
  assign br_cond    = r_br_cond;
  assign st_data    = r_st_data;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: spec-level decode/occupancy model checked
// every cycle, plus hand-computed literal expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] SrcA;
  logic [63:0] SrcB;
  logic [1:0]  ALUControl;
  logic [2:0]  br_cond;
  logic [63:0] st_data;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.BITS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .br_cond    (br_cond),
    .st_data    (st_data),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic        legal;
    logic        is_store;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] st;
    logic [1:0]  alu;
    logic [2:0]  br;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] sext12(input int v);
    int     s;
    longint l;
    s = v;
    if (s >= 2048) s = s - 4096;
    l = longint'(s);
    return l;
  endfunction

  // What the stage must present for one accepted instruction
  function automatic exp_t exp_decode(input logic [31:0] ins, input logic [63:0] r1,
                                      input logic [63:0] r2);
    exp_t e;
    int   opc;
    int   f3;
    int   f7;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    e.legal = 1'b1;
    e.is_store = 1'b0;
    e.a = r1;
    e.b = r2;
    e.st = r2;
    e.alu = 2'd0;
    e.br = 3'd0;
    case (opc)
      'h33: begin
        if (f3 == 0 && f7 == 0)          e.alu = 2'd0;
        else if (f3 == 0 && f7 == 'h20)  e.alu = 2'd1;
        else if (f3 == 7 && f7 == 0)     e.alu = 2'd2;
        else if (f3 == 6 && f7 == 0)     e.alu = 2'd3;
        else                             e.legal = 1'b0;
      end
      'h13: begin
        e.b = sext12(int'(ins[31:20]));
        if (f3 == 0)      e.alu = 2'd0;
        else if (f3 == 7) e.alu = 2'd2;
        else if (f3 == 6) e.alu = 2'd3;
        else              e.legal = 1'b0;
      end
      'h03: e.b = sext12(int'(ins[31:20]));
      'h23: begin
        e.b = sext12(int'(ins[31:25]) * 32 + int'(ins[11:7]));
        e.is_store = 1'b1;
      end
      'h63: begin
        e.alu = 2'd1;
        case (f3)
          0: e.br = 3'd1;
          1: e.br = 3'd2;
          4: e.br = 3'd3;
          5: e.br = 3'd4;
          6: e.br = 3'd5;
          7: e.br = 3'd6;
          default: e.legal = 1'b0;
        endcase
      end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) begin
      e.alu = 2'd0;
      e.br = 3'd0;
    end
    return e;
  endfunction

  logic m_valid = 1'b0;
  exp_t m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_e <= exp_decode(instr, rs1_val, rs2_val);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 64'(out_valid), 64'(m_valid));
      chk("m_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      if (m_valid) begin
        chk("m_alu", 64'(ALUControl), 64'(m_e.alu));
        chk("m_br_cond", 64'(br_cond), 64'(m_e.br));
        chk("m_illegal", 64'(illegal), 64'(!m_e.legal));
        if (m_e.legal) begin
          chk("m_srca", SrcA, m_e.a);
          chk("m_srcb", SrcB, m_e.b);
        end
        if (m_e.is_store) chk("m_st_data", st_data, m_e.st);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_srca"}, SrcA, 64'd0);
    chk({tag, "_srcb"}, SrcB, 64'd0);
    chk({tag, "_st_data"}, st_data, 64'd0);
    chk({tag, "_alu"}, 64'(ALUControl), 64'd0);
    chk({tag, "_br_cond"}, 64'(br_cond), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, input logic ordy, input logic fl);
    in_valid = v;
    instr = ins;
    rs1_val = a;
    rs2_val = b;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic ordy);
    logic took;
    in_valid = 1'b1;
    instr = ins;
    rs1_val = a;
    rs2_val = b;
    out_ready = ordy;
    flush = 1'b0;
    took = 1'b0;
    for (int t = 0; t < 4 && !took; t++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted instr=%h", ins);
    end
  endtask

  logic [31:0] vec [0:15];

  initial begin
    vec = '{32'h0020F1B3, 32'h0020E1B3, 32'h0F016093, 32'hFF017093,
            32'hFF813283, 32'h02713423, 32'hFE712E23, 32'h00209063,
            32'h0020C063, 32'h0020D063, 32'h0020E063, 32'h0020F063,
            32'h0020A063, 32'h0020C1B3, 32'h00002013, 32'h202081B3};

    rst_n = 1'b1;
    in_valid = 1'b0;
    instr = '0;
    rs1_val = '0;
    rs2_val = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // add x3,x1,x2
    step(1'b1, 32'h002081B3, 64'd5, 64'd7, 1'b1, 1'b0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_srca", SrcA, 64'd5);
    chk("add_srcb", SrcB, 64'd7);
    chk("add_alu", 64'(ALUControl), 64'd0);
    chk("add_br", 64'(br_cond), 64'd0);
    chk("add_illegal", 64'(illegal), 64'd0);

    // addi x1,x0,-1
    step(1'b1, 32'hFFF00093, 64'd0, 64'd123, 1'b1, 1'b0);
    chk("addi_srcb", SrcB, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_alu", 64'(ALUControl), 64'd0);

    // beq then sub back-to-back
    step(1'b1, 32'h00208063, 64'd9, 64'd9, 1'b1, 1'b0);
    chk("beq_br", 64'(br_cond), 64'd1);
    chk("beq_alu", 64'(ALUControl), 64'd1);
    step(1'b1, 32'h402081B3, 64'd20, 64'd3, 1'b1, 1'b0);
    chk("sub_valid", 64'(out_valid), 64'd1);
    chk("sub_alu", 64'(ALUControl), 64'd1);
    chk("sub_br", 64'(br_cond), 64'd0);
    chk("sub_srca", SrcA, 64'd20);

    // ld / sd / sw immediates
    step(1'b1, 32'hFF813283, 64'd100, 64'd1, 1'b1, 1'b0);
    chk("ld_srcb", SrcB, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 32'h02713423, 64'd200, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    chk("sd_srcb", SrcB, 64'd40);
    chk("sd_st_data", st_data, 64'h1234_5678_9ABC_DEF0);
    step(1'b1, 32'hFE712E23, 64'd300, 64'd77, 1'b1, 1'b0);
    chk("sw_srcb", SrcB, 64'hFFFF_FFFF_FFFF_FFFC);

    // Backpressure with flush in the middle
    step(1'b1, 32'h002081B3, 64'd1, 64'd2, 1'b1, 1'b0);
    step(1'b1, 32'h402081B3, 64'd30, 64'd4, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_srca", SrcA, 64'd1);
    chk("bp_hold_alu", 64'(ALUControl), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    step(1'b1, 32'h402081B3, 64'd30, 64'd4, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h402081B3, 64'd30, 64'd4, 1'b0, 1'b0);
    chk("after_flush_srca", SrcA, 64'd30);
    chk("after_flush_in_ready", 64'(in_ready), 64'd0);

    // Illegal opcode
    step(1'b1, 32'h0000007F, 64'd8, 64'd9, 1'b1, 1'b0);
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_alu", 64'(ALUControl), 64'd0);
    chk("ill_br", 64'(br_cond), 64'd0);

    // Async reset mid-transfer
    step(1'b1, 32'h002081B3, 64'd11, 64'd22, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      send(vec[i], 64'h1000 + 64'(i), {32'hDEAD_0000, 32'(i)}, (i % 3) != 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
